i2c_target_regs: RTL and testbench

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

---
 rtl/i2c_target_regs_if.sv | 36 +++
 rtl/i2c_target_regs.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_regs_if.sv
// Bundles the I2C bus wires and register-write outputs of i2c_target_regs.
// SDA is resolved as a wired-AND of the controller and target drivers.
interface i2c_target_regs_if #(
    parameter int PtrW = 4
);
    logic            scl;
    logic            sda_ctrl;
    logic            sda_tgt;
    logic            sda;
    logic            busy;
    logic            wr_strobe;
    logic [PtrW-1:0] wr_addr;
    logic [7:0]      wr_data;

    assign sda = sda_ctrl & sda_tgt;

    modport master (
        output scl,
        output sda_ctrl,
        input  sda,
        input  busy,
        input  wr_strobe,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  scl,
        input  sda,
        output sda_tgt,
        output busy,
        output wr_strobe,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target exposing a small byte register file: pointer byte then
// auto-incrementing writes, and auto-incrementing reads. No clock stretching.
module i2c_target_regs #(
    parameter logic [6:0] TargetAddr = 7'h50,
    parameter int         NumRegs    = 16,
    localparam int        PtrW       = $clog2(NumRegs)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            scl_i,
    input  logic            sda_i,
    output logic            sda_o,
    output logic            busy_o,
    output logic            wr_strobe_o,
    output logic [PtrW-1:0] wr_addr_o,
    output logic [7:0]      wr_data_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_BYTE,
        ST_RX_ACK,
        ST_TX_BYTE,
        ST_TX_ACK
    } state_e;

    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    state_e          r_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [7:0]      r_tx;
    logic            r_addr_phase;
    logic            r_ptr_phase;
    logic            r_ack_phase;
    logic            r_rw;
    logic [PtrW-1:0] r_ptr;
    logic [7:0]      r_regs [NumRegs];
    logic            r_sda_o;
    logic            r_busy;
    logic            r_wr_strobe;
    logic [PtrW-1:0] r_wr_addr;
    logic [7:0]      r_wr_data;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl_i;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_i;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte     = {r_shift[6:0], r_sda_s2};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_tx         <= 8'h00;
            r_addr_phase <= 1'b0;
            r_ptr_phase  <= 1'b0;
            r_ack_phase  <= 1'b0;
            r_rw         <= 1'b0;
            r_ptr        <= '0;
            r_sda_o      <= 1'b1;
            r_busy       <= 1'b0;
            r_wr_strobe  <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= 8'h00;
            // NOTE: the register file is reset because its power-up contents are
            // architecturally visible (each register starts at its own index).
            for (int i = 0; i < NumRegs; i++) begin
                r_regs[i] <= 8'(i);
            end
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_stop) begin
                r_state      <= ST_IDLE;
                r_sda_o      <= 1'b1;
                r_busy       <= 1'b0;
                r_addr_phase <= 1'b0;
                r_ptr_phase  <= 1'b0;
            end else if (w_start) begin
                r_state      <= ST_RX_BYTE;
                r_addr_phase <= 1'b1;
                r_ptr_phase  <= 1'b0;
                r_bit_cnt    <= 3'd0;
                r_sda_o      <= 1'b1;
                r_busy       <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: ;
                    ST_RX_BYTE: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_ack_phase <= 1'b0;
                                if (!r_addr_phase) begin
                                    r_state <= ST_RX_ACK;
                                end else if (w_byte[7:1] == TargetAddr) begin
                                    r_state <= ST_RX_ACK;
                                    r_busy  <= 1'b1;
                                    r_rw    <= w_byte[0];
                                end else begin
                                    r_state      <= ST_IDLE;
                                    r_addr_phase <= 1'b0;
                                end
                            end
                        end
                    end
                    // First falling edge starts the ACK (and commits the byte); second ends it.
                    ST_RX_ACK: begin
                        if (w_scl_fall && !r_ack_phase) begin
                            r_ack_phase <= 1'b1;
                            r_sda_o     <= 1'b0;
                            if (!r_addr_phase && r_ptr_phase) begin
                                r_ptr       <= r_shift[PtrW-1:0];
                                r_ptr_phase <= 1'b0;
                            end else if (!r_addr_phase) begin
                                r_regs[r_ptr] <= r_shift;
                                r_wr_strobe   <= 1'b1;
                                r_wr_addr     <= r_ptr;
                                r_wr_data     <= r_shift;
                                r_ptr         <= r_ptr + 1'b1;
                            end
                        end else if (w_scl_fall) begin
                            r_bit_cnt    <= 3'd0;
                            r_addr_phase <= 1'b0;
                            if (r_addr_phase && r_rw) begin
                                r_state <= ST_TX_BYTE;
                                r_sda_o <= r_regs[r_ptr][7];
                                r_tx    <= {r_regs[r_ptr][6:0], 1'b0};
                            end else begin
                                r_state     <= ST_RX_BYTE;
                                r_ptr_phase <= r_addr_phase;
                                r_sda_o     <= 1'b1;
                            end
                        end
                    end
                    ST_TX_BYTE: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 3'd7) begin
                                r_state     <= ST_TX_ACK;
                                r_sda_o     <= 1'b1;
                                r_ack_phase <= 1'b0;
                            end else begin
                                r_sda_o   <= r_tx[7];
                                r_tx      <= {r_tx[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    // Pointer advances on the controller's ACK; the next byte starts on the following fall.
                    ST_TX_ACK: begin
                        if (w_scl_rise) begin
                            if (r_sda_s2) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_sda_o <= 1'b1;
                            end else begin
                                r_ptr       <= r_ptr + 1'b1;
                                r_ack_phase <= 1'b1;
                            end
                        end else if (w_scl_fall && r_ack_phase) begin
                            r_state   <= ST_TX_BYTE;
                            r_bit_cnt <= 3'd0;
                            r_sda_o   <= r_regs[r_ptr][7];
                            r_tx      <= {r_regs[r_ptr][6:0], 1'b0};
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign sda_o       = r_sda_o;
    assign busy_o      = r_busy;
    assign wr_strobe_o = r_wr_strobe;
    assign wr_addr_o   = r_wr_addr;
    assign wr_data_o   = r_wr_data;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C controller, write-strobe
// monitor, a table of pointer/write/readback vectors and hand-built corner sequences.
module tb_i2c_target_regs;

    localparam int Q = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_target_regs_if #(.PtrW(4)) bus ();

    i2c_target_regs #(
        .TargetAddr(7'h50),
        .NumRegs   (16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .scl_i      (bus.scl),
        .sda_i      (bus.sda),
        .sda_o      (bus.sda_tgt),
        .busy_o     (bus.busy),
        .wr_strobe_o(bus.wr_strobe),
        .wr_addr_o  (bus.wr_addr),
        .wr_data_o  (bus.wr_data)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_sda_low = 0;
    int n_busy = 0;
    logic [3:0] q_addr[$];
    logic [7:0] q_data[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_strobe) begin
                q_addr.push_back(bus.wr_addr);
                q_data.push_back(bus.wr_data);
            end
            if (!bus.sda_tgt) n_sda_low++;
            if (bus.busy) n_busy++;
        end
    end

    typedef struct {
        logic [7:0] ptr_byte;
        logic [7:0] data;
        logic [3:0] exp_addr;
        logic [7:0] exp_data;
        logic [7:0] exp_rd;
    } wr_vec_t;

    wr_vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic write_bit(input logic b);
        bus.sda_ctrl = b;
        tick_q();
        bus.scl = 1'b1;
        tick_q();
        tick_q();
        bus.scl = 1'b0;
        tick_q();
    endtask

    task automatic read_bit(output logic b);
        bus.sda_ctrl = 1'b1;
        tick_q();
        bus.scl = 1'b1;
        tick_q();
        b = bus.sda;
        tick_q();
        bus.scl = 1'b0;
        tick_q();
    endtask

    task automatic i2c_start();
        bus.sda_ctrl = 1'b1;
        tick_q();
        bus.scl = 1'b1;
        tick_q();
        bus.sda_ctrl = 1'b0;
        tick_q();
        bus.scl = 1'b0;
        tick_q();
    endtask

    task automatic i2c_stop();
        bus.sda_ctrl = 1'b0;
        tick_q();
        bus.scl = 1'b1;
        tick_q();
        bus.sda_ctrl = 1'b1;
        tick_q();
        tick_q();
    endtask

    task automatic send(input string name, input logic [7:0] b, input logic exp_ack);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(a);
        check({name, " ack"}, {31'd0, a}, {31'd0, exp_ack});
    endtask

    task automatic read_chk(input string name, input logic nack, input logic [7:0] exp);
        logic [7:0] d;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
        check(name, {24'd0, d}, {24'd0, exp});
    endtask

    task automatic set_ptr_read(input string name, input logic [7:0] ptr);
        i2c_start();
        send({name, " addr_w"}, 8'hA0, 1'b0);
        send({name, " ptr"}, ptr, 1'b0);
        i2c_start();
        send({name, " addr_r"}, 8'hA1, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int low0;
        int busy0;

        vecs[0] = '{ptr_byte: 8'h27, data: 8'hA5, exp_addr: 4'h7, exp_data: 8'hA5, exp_rd: 8'hA5};
        vecs[1] = '{ptr_byte: 8'hF9, data: 8'h3C, exp_addr: 4'h9, exp_data: 8'h3C, exp_rd: 8'h3C};
        vecs[2] = '{ptr_byte: 8'h0B, data: 8'hFF, exp_addr: 4'hB, exp_data: 8'hFF, exp_rd: 8'hFF};
        vecs[3] = '{ptr_byte: 8'h0C, data: 8'h96, exp_addr: 4'hC, exp_data: 8'h96, exp_rd: 8'h96};

        bus.scl = 1'b1;
        bus.sda_ctrl = 1'b1;
        repeat (3) @(negedge clk);
        check("reset sda_o", {31'd0, bus.sda_tgt}, 32'd1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("reset busy_o", {31'd0, bus.busy}, 32'd0);
        check("reset wr_strobe_o", {31'd0, bus.wr_strobe}, 32'd0);
        check("reset wr_addr_o", {28'd0, bus.wr_addr}, 32'd0);
        check("reset wr_data_o", {24'd0, bus.wr_data}, 32'd0);

        // Reset contents and pointer: read from ptr 0 with ACK, then NACK.
        i2c_start();
        send("init addr_r", 8'hA1, 1'b0);
        check("init busy after addr", {31'd0, bus.busy}, 32'd1);
        read_chk("init reg0", 1'b0, 8'h00);
        read_chk("init reg1", 1'b1, 8'h01);
        i2c_stop();

        // Pointer then two data writes.
        base = q_addr.size();
        i2c_start();
        send("wr addr", 8'hA0, 1'b0);
        check("wr busy after addr", {31'd0, bus.busy}, 32'd1);
        send("wr ptr", 8'h03, 1'b0);
        send("wr d0", 8'h5A, 1'b0);
        send("wr d1", 8'hC3, 1'b0);
        i2c_stop();
        check("wr strobe count", q_addr.size() - base, 32'd2);
        check("wr strobe0 addr", {28'd0, q_addr[base]}, 32'd3);
        check("wr strobe0 data", {24'd0, q_data[base]}, 32'h5A);
        check("wr strobe1 addr", {28'd0, q_addr[base+1]}, 32'd4);
        check("wr strobe1 data", {24'd0, q_data[base+1]}, 32'hC3);
        check("wr busy after stop", {31'd0, bus.busy}, 32'd0);
        i2c_start();
        send("ptr5 addr_r", 8'hA1, 1'b0);
        read_chk("ptr5 read", 1'b1, 8'h05);
        i2c_stop();

        // Repeated-start read of the bytes just written.
        set_ptr_read("rd", 8'h03);
        read_chk("rd reg3", 1'b0, 8'h5A);
        read_chk("rd reg4", 1'b1, 8'hC3);
        check("rd sda released after nack", {31'd0, bus.sda_tgt}, 32'd1);
        check("rd busy after nack", {31'd0, bus.busy}, 32'd0);
        i2c_stop();
        check("rd busy after stop", {31'd0, bus.busy}, 32'd0);

        // Wrong address: target stays silent.
        base = q_addr.size();
        low0 = n_sda_low;
        busy0 = n_busy;
        i2c_start();
        send("miss addr", 8'hA2, 1'b1);
        send("miss data", 8'h00, 1'b1);
        i2c_stop();
        check("miss sda low cycles", n_sda_low - low0, 32'd0);
        check("miss busy cycles", n_busy - busy0, 32'd0);
        check("miss strobes", q_addr.size() - base, 32'd0);

        // Write wraps from register 15 to register 0.
        base = q_addr.size();
        i2c_start();
        send("wrap addr", 8'hA0, 1'b0);
        send("wrap ptr", 8'h0F, 1'b0);
        send("wrap d0", 8'h11, 1'b0);
        send("wrap d1", 8'h22, 1'b0);
        i2c_stop();
        check("wrap strobe count", q_addr.size() - base, 32'd2);
        check("wrap strobe0 addr", {28'd0, q_addr[base]}, 32'd15);
        check("wrap strobe0 data", {24'd0, q_data[base]}, 32'h11);
        check("wrap strobe1 addr", {28'd0, q_addr[base+1]}, 32'd0);
        check("wrap strobe1 data", {24'd0, q_data[base+1]}, 32'h22);
        set_ptr_read("wrap rd0", 8'h00);
        read_chk("wrap reg0", 1'b1, 8'h22);
        i2c_stop();
        set_ptr_read("wrap rd15", 8'h0F);
        read_chk("wrap reg15", 1'b0, 8'h11);
        read_chk("wrap read reg0", 1'b1, 8'h22);
        i2c_stop();

        // STOP in the middle of a data byte discards it.
        base = q_addr.size();
        i2c_start();
        send("part addr", 8'hA0, 1'b0);
        send("part ptr", 8'h02, 1'b0);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b1);
        i2c_stop();
        check("part strobes", q_addr.size() - base, 32'd0);
        check("part sda_o", {31'd0, bus.sda_tgt}, 32'd1);
        check("part busy", {31'd0, bus.busy}, 32'd0);
        set_ptr_read("part rd", 8'h02);
        read_chk("part reg2", 1'b1, 8'h02);
        i2c_stop();

        for (int v = 0; v < 4; v++) begin
            base = q_addr.size();
            i2c_start();
            send($sformatf("vec%0d addr", v), 8'hA0, 1'b0);
            send($sformatf("vec%0d ptr", v), vecs[v].ptr_byte, 1'b0);
            send($sformatf("vec%0d data", v), vecs[v].data, 1'b0);
            i2c_stop();
            check($sformatf("vec%0d strobe count", v), q_addr.size() - base, 32'd1);
            check($sformatf("vec%0d strobe addr", v), {28'd0, q_addr[base]}, {28'd0, vecs[v].exp_addr});
            check($sformatf("vec%0d strobe data", v), {24'd0, q_data[base]}, {24'd0, vecs[v].exp_data});
            set_ptr_read($sformatf("vec%0d rd", v), vecs[v].ptr_byte);
            read_chk($sformatf("vec%0d readback", v), 1'b1, vecs[v].exp_rd);
            i2c_stop();
            check($sformatf("vec%0d read strobes", v), q_addr.size() - base, 32'd1);
        end

        // Reset while the target drives bit 7 (0) of reg0 = 0x22.
        set_ptr_read("rst", 8'h00);
        check("rst pre sda_o driven", {31'd0, bus.sda_tgt}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst sda_o released", {31'd0, bus.sda_tgt}, 32'd1);
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst wr_addr_o", {28'd0, bus.wr_addr}, 32'd0);
        check("rst wr_data_o", {24'd0, bus.wr_data}, 32'd0);
        bus.sda_ctrl = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Clocked address bits without a START must be ignored.
        base = q_addr.size();
        low0 = n_sda_low;
        busy0 = n_busy;
        for (int i = 7; i >= 0; i--) write_bit(vecs[0].ptr_byte[i] ^ 1'b1);
        write_bit(1'b1);
        check("post-rst sda low cycles", n_sda_low - low0, 32'd0);
        check("post-rst busy cycles", n_busy - busy0, 32'd0);
        check("post-rst strobes", q_addr.size() - base, 32'd0);

        i2c_start();
        send("post-rst addr_r", 8'hA1, 1'b0);
        read_chk("post-rst reg0", 1'b0, 8'h00);
        read_chk("post-rst reg1", 1'b1, 8'h01);
        i2c_stop();
        set_ptr_read("post-rst rd3", 8'h03);
        read_chk("post-rst reg3", 1'b1, 8'h03);
        i2c_stop();
        set_ptr_read("post-rst rd7", 8'h07);
        read_chk("post-rst reg7", 1'b1, 8'h07);
        i2c_stop();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
